// File: rtl/inv_key_expansion.sv
// AES-128 decryption key schedule: emits round keys 10 down to 0, one per valid/ready handshake.
// Optional INV_KEY_PRECOMPUTE_EN: load_cipher lets key_in be the cipher key, run forward to round 10 first.
module inv_key_expansion #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef INV_KEY_PRECOMPUTE_EN
  input  logic         load_cipher,
`endif
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, OUT, SUB, UPD
`ifdef INV_KEY_PRECOMPUTE_EN
    , FSUB, FUPD
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic [31:0]  sub_q;
  logic         done_q;
  logic [31:0]  n0, n1, n2, n3, sbox_in;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // b^254 is the GF(2^8) multiplicative inverse (and maps 0 to 0), followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign n0 = key_q[31:0];
  assign n1 = key_q[63:32];
  assign n2 = key_q[95:64];
  assign n3 = key_q[127:96];

`ifdef INV_KEY_PRECOMPUTE_EN
  logic [31:0] f0, f1, f2, f3;
  assign sbox_in = (state_q == FSUB) ? n3 : (n3 ^ n2);
  assign f0 = n0 ^ sub_q ^ {rcon_q, 24'h0};
  assign f1 = n1 ^ f0;
  assign f2 = n2 ^ f1;
  assign f3 = n3 ^ f2;
`else
  assign sbox_in = n3 ^ n2;
`endif

  assign accept    = (state_q == OUT) && key_ready;
  assign key_out   = key_q;
  assign round_out = round_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    key_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef INV_KEY_PRECOMPUTE_EN
          state_d = load_cipher ? FSUB : OUT;
`else
          state_d = OUT;
`endif
        end
      end
      OUT: begin
        key_valid = 1'b1;
        if (key_ready) state_d = (round_q == 4'd0) ? IDLE : SUB;
      end
      SUB: state_d = UPD;
      UPD: state_d = OUT;
`ifdef INV_KEY_PRECOMPUTE_EN
      FSUB: state_d = FUPD;
      FUPD: state_d = (round_q == 4'(NR - 1)) ? OUT : FSUB;
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the sbox result register is reset as well, so a reset mid-round never leaves a stale SubWord behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      sub_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= accept && (round_q == 4'd0);
      sub_q  <= {sbox(sbox_in[23:16]), sbox(sbox_in[15:8]), sbox(sbox_in[7:0]), sbox(sbox_in[31:24])};
      case (state_q)
        IDLE: begin
          if (start) begin
            key_q <= key_in;
`ifdef INV_KEY_PRECOMPUTE_EN
            if (load_cipher) begin
              round_q <= 4'd0;
              rcon_q  <= 8'h01;
            end else begin
              round_q <= 4'(NR);
              rcon_q  <= 8'h36;
            end
`else
            round_q <= 4'(NR);
            rcon_q  <= 8'h36;
`endif
          end
        end
        UPD: begin
          key_q   <= {n3 ^ n2, n2 ^ n1, n1 ^ n0, n0 ^ sub_q ^ {rcon_q, 24'h0}};
          round_q <= round_q - 4'd1;
          rcon_q  <= (rcon_q == 8'h1B) ? 8'h80 : (rcon_q >> 1);
        end
`ifdef INV_KEY_PRECOMPUTE_EN
        FUPD: begin
          key_q   <= {f3, f2, f1, f0};
          round_q <= round_q + 4'd1;
          // The last forward step hands over to the reverse walk, which starts at Rcon[10].
          rcon_q  <= (round_q == 4'(NR - 1)) ? 8'h36 : xtime(rcon_q);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Randomized self-checking bench for inv_key_expansion against a word-array AES-128 key schedule model.
module tb_inv_key_expansion;

  localparam logic [127:0] KAT_R10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
  localparam logic [127:0] KAT_R9  = 128'h575c006e_28d12941_19fadc21_ac7766f3;
  localparam logic [127:0] KAT_R1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
  localparam logic [127:0] KAT_R0  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;

  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [127:0] key_in, key_out;
  logic [3:0]   round_out;
  logic         key_valid, busy, done;
`ifdef INV_KEY_PRECOMPUTE_EN
  logic         load_cipher;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [11];
  logic [127:0] exp_keys [11];

  always #5 clk = ~clk;

  inv_key_expansion dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef INV_KEY_PRECOMPUTE_EN
    .load_cipher (load_cipher),
`endif
    .key_in    (key_in),
    .key_out   (key_out),
    .round_out (round_out),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p & 'hff;
  endfunction

  // S-box from a brute-force inverse search plus the bitwise affine equation.
  task automatic build_tables();
    logic [7:0] inv, s, c;
    int r;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x, y) == 1) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_tab[x] = s;
    end
    r = 1;
    rcon_tab[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon_tab[i] = 8'(r);
      r = gmul(r, 2);
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]};
  endfunction

  // Textbook w[0..43] schedule, filled forward from the cipher key or backward from the round-10 key.
  task automatic build_model(input logic [127:0] k, input bit from_cipher);
    logic [31:0] w [44];
    logic [31:0] t;
    if (from_cipher) begin
      for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
      for (int i = 4; i < 44; i++) begin
        t = ((i % 4) == 0) ? (sub_rot(w[i-1]) ^ {rcon_tab[i/4], 24'h0}) : w[i-1];
        w[i] = w[i-4] ^ t;
      end
    end else begin
      for (int j = 0; j < 4; j++) w[40+j] = k[32*j +: 32];
      for (int i = 39; i >= 0; i--) begin
        t = ((i % 4) == 0) ? (sub_rot(w[i+3]) ^ {rcon_tab[i/4 + 1], 24'h0}) : w[i+3];
        w[i] = w[i+4] ^ t;
      end
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 128'(key_valid), 128'd0);
    check({tag, "_busy"},  128'(busy),      128'd0);
    check({tag, "_done"},  128'(done),      128'd0);
    check({tag, "_key"},   key_out,         128'd0);
    check({tag, "_round"}, 128'(round_out), 128'd0);
  endtask

  task automatic run_keys(input logic [127:0] k, input bit load, input bit rnd, input bit poke, input bit kat);
    int idx, cyc, last_acc, first_lat;
    bit stalled, waiting, poked;
    logic [127:0] held_key;
    logic [3:0]   held_round;
    build_model(k, load);
    first_lat = load ? 21 : 1;
    idx = 0; cyc = 0; last_acc = 0; stalled = 0; waiting = 1; poked = 0;
    held_key = '0; held_round = '0;
    @(negedge clk);
    start = 1'b1; key_in = k; key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef INV_KEY_PRECOMPUTE_EN
    load_cipher = load;
`endif
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom}; cyc = 1;
`ifdef INV_KEY_PRECOMPUTE_EN
    load_cipher = 1'($urandom_range(0, 1));
`endif
    while (idx < 11 && cyc < 400) begin
      if (key_valid) begin
        if (waiting) begin
          if (idx == 0) check("first_lat", 128'(cyc), 128'(first_lat));
          else          check("acc_gap", 128'(cyc - last_acc), 128'd3);
          check("busy_run", 128'(busy), 128'd1);
          waiting = 0;
        end
        if (stalled) begin
          check("hold_key", key_out, held_key);
          check("hold_round", 128'(round_out), 128'(held_round));
        end
        key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (key_ready) begin
          check("key", key_out, exp_keys[10-idx]);
          check("round", 128'(round_out), 128'(10 - idx));
          if (kat && idx == 0)  check("kat_r10", key_out, KAT_R10);
          if (kat && idx == 1)  check("kat_r9",  key_out, KAT_R9);
          if (kat && idx == 9)  check("kat_r1",  key_out, KAT_R1);
          if (kat && idx == 10) check("kat_r0",  key_out, KAT_R0);
          last_acc = cyc; idx++; stalled = 0; waiting = 1;
        end else begin
          stalled = 1; held_key = key_out; held_round = round_out;
        end
      end else begin
        key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (poke && !poked && key_valid && round_out == 4'd5) begin
        start = 1'b1; poked = 1; key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      start = 1'b0; cyc++;
    end
    if (idx < 11) check("timeout_keys", 128'(idx), 128'd11);
    check("done_pulse", 128'(done), 128'd1);
    if (!rnd) check("done_cyc", 128'(cyc), 128'(first_lat + 31));
    key_ready = 1'b1;
    @(negedge clk);
    check("done_drop", 128'(done), 128'd0);
    check("busy_end", 128'(busy), 128'd0);
    check("valid_end", 128'(key_valid), 128'd0);
  endtask

  task automatic reset_mid(input logic [127:0] k);
    int cyc = 0;
    @(negedge clk);
    start = 1'b1; key_in = k; key_ready = 1'b1;
`ifdef INV_KEY_PRECOMPUTE_EN
    load_cipher = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    while (!(key_valid && round_out == 4'd7) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_r7", 128'(round_out), 128'd7);
    @(negedge clk);
    @(negedge clk);
    check("upd_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] rk;
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
`ifdef INV_KEY_PRECOMPUTE_EN
    load_cipher = 1'b0;
`endif
    build_tables();
    @(negedge clk);
    check_idle_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    run_keys(KAT_R10, 1'b0, 1'b0, 1'b0, 1'b1);
    run_keys(KAT_R10, 1'b0, 1'b1, 1'b0, 1'b1);
    run_keys(KAT_R10, 1'b0, 1'b0, 1'b1, 1'b1);
    reset_mid(KAT_R10);
    run_keys(KAT_R10, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_keys(rk, 1'b0, 1'b1, 1'b0, 1'b0);
    end
`ifdef INV_KEY_PRECOMPUTE_EN
    run_keys(KAT_R0, 1'b1, 1'b0, 1'b0, 1'b1);
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_keys(rk, 1'b1, 1'b1, 1'b0, 1'b0);
    run_keys(KAT_R10, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
